antidroop_ctrl: RTL and testbench

Per-pulse sequencer for a bank of anti-droop IIR channels. It detects the beam trigger and times an active window plus a holdoff, then commits host-written tap weights only in the quiet period after holdoff. It also supervises the channels' overflow flags, issuing their clear strobes and keeping sticky status and a pulse counter for the register interface. It sits between the host register block and the NCH anti-droop filter instances on the ADC clock.

---
 rtl/antidroop_ctrl_pkg.sv | 26 ++
 rtl/antidroop_ctrl_sat_cnt8.sv | 31 +++
 rtl/antidroop_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_antidroop_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antidroop_ctrl_pkg.sv
// Shared types and constants for the anti-droop pulse sequencer.
package antidroop_pkg;

   // Sequencer states; the encoding is also driven out on dbg_state.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_HOLDOFF = 2'd2,
      ST_COMMIT  = 2'd3
   } state_e;

   // Signed tap weight width per channel.
   localparam int WEIGHT_W = 7;

   // Control word (address NCH) bit positions.
   localparam int CTRL_ACC_CLR_BIT  = 0;
   localparam int CTRL_STAT_CLR_BIT = 1;

   // Width of a down-counter that must hold max(a, b) - 1; never below 1 bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/antidroop_ctrl_sat_cnt8.sv
// 8-bit counter that increments on inc_i and sticks at 255.
module sat_cnt8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_i,
   output logic [7:0] cnt_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: hold at all-ones once reached.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/antidroop_ctrl.sv
// Per-pulse sequencer for the anti-droop IIR channel bank: times the beam
// window and holdoff, commits host weights in the quiet period, and
// supervises channel overflow flags.
//
// Host interface: cfg_wr is a single-cycle strobe with no back-pressure;
// cfg_addr/cfg_data are sampled on the same rising edge and every write is
// accepted in every state (there is no ready; the block never stalls it).
module antidroop_ctrl
   import antidroop_pkg::*;
#(
   parameter  int NCH         = 3,
   parameter  int WINDOW_LEN  = 164,
   parameter  int HOLDOFF_LEN = 16,
   localparam int ADDR_W      = $clog2(NCH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    trig,
   input  logic                    cfg_wr,
   input  logic [ADDR_W-1:0]       cfg_addr,
   input  logic [7:0]              cfg_data,
   input  logic [NCH-1:0]          oflow_in,
   output logic [NCH*WEIGHT_W-1:0] tap_weight,
   output logic                    acc_clr_en,
   output logic                    oflow_clr,
   output logic                    window,
   output logic                    busy,
   output logic                    commit_done,
   output logic [NCH-1:0]          oflow_status,
   output logic [7:0]              oflow_pulse_cnt,
   output logic [7:0]              missed_trig,
   output logic [1:0]              dbg_state
);

   localparam int CNT_W = cnt_width(WINDOW_LEN, HOLDOFF_LEN);

   // Trigger synchroniser and registered rising edge.
   logic trig_a_q, trig_b_q, trig_edge_q;

   // Sequencer.
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Decoded state, shared by the datapath.
   logic is_commit;
   logic in_window;

   // Shadow (host-written) and committed configuration.
   logic [NCH*WEIGHT_W-1:0] shadow_w_q;
   logic                    shadow_acc_q;
   logic                    clr_pending_q;
   logic [NCH*WEIGHT_W-1:0] tap_weight_q;
   logic                    acc_clr_en_q;
   logic                    ctrl_wr;

   // Overflow supervision.
   logic [NCH-1:0] oflow_status_q;
   logic           win_oflow_q;

   // Only the low 7 data bits carry weights; the MSB has no meaning.
   logic unused_cfg_msb;
   assign unused_cfg_msb = cfg_data[7];

   // Two-flop synchroniser plus a registered edge so the window starts two
   // cycles after trig is first sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_a_q    <= 1'b0;
         trig_b_q    <= 1'b0;
         trig_edge_q <= 1'b0;
      end else begin
         trig_a_q    <= trig;
         trig_b_q    <= trig_a_q;
         trig_edge_q <= trig_a_q & ~trig_b_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: a triggered window, a holdoff, then a single commit cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trig_edge_q) begin
               state_d = ST_ACTIVE;
               cnt_d   = CNT_W'(WINDOW_LEN - 1);
            end
         end
         ST_ACTIVE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLDOFF;
               cnt_d   = CNT_W'(HOLDOFF_LEN - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = ST_COMMIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State decode; all of these come straight from the state register.
   always_comb begin
      window      = (state_q == ST_ACTIVE);
      busy        = (state_q != ST_IDLE);
      is_commit   = (state_q == ST_COMMIT);
      in_window   = (state_q == ST_ACTIVE) || (state_q == ST_HOLDOFF);
      commit_done = is_commit;
      oflow_clr   = is_commit && clr_pending_q;
   end

   assign ctrl_wr = cfg_wr && (cfg_addr == ADDR_W'(NCH));

   // Shadow registers; a write during COMMIT lands after that cycle's copy.
   // A status-clear request written in COMMIT re-arms for the next commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_w_q    <= '0;
         shadow_acc_q  <= 1'b0;
         clr_pending_q <= 1'b0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            if (cfg_wr && (cfg_addr == ADDR_W'(n))) begin
               shadow_w_q[n*WEIGHT_W +: WEIGHT_W] <= cfg_data[WEIGHT_W-1:0];
            end
         end
         if (is_commit) begin
            clr_pending_q <= 1'b0;
         end
         if (ctrl_wr) begin
            shadow_acc_q <= cfg_data[CTRL_ACC_CLR_BIT];
            if (cfg_data[CTRL_STAT_CLR_BIT]) begin
               clr_pending_q <= 1'b1;
            end
         end
      end
   end

   // Committed configuration, updated only at the end of COMMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_weight_q <= '0;
         acc_clr_en_q <= 1'b0;
      end else if (is_commit) begin
         tap_weight_q <= shadow_w_q;
         acc_clr_en_q <= shadow_acc_q;
      end
   end

   // Sticky overflow status and per-window overflow flag; a clear in COMMIT
   // wins, and overflow inputs seen in COMMIT are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oflow_status_q <= '0;
         win_oflow_q    <= 1'b0;
      end else begin
         if (oflow_clr) begin
            oflow_status_q <= '0;
         end else if (!is_commit) begin
            oflow_status_q <= oflow_status_q | oflow_in;
         end
         if (is_commit) begin
            win_oflow_q <= 1'b0;
         end else if (in_window && (|oflow_in)) begin
            win_oflow_q <= 1'b1;
         end
      end
   end

   // Windows that saw any overflow.
   sat_cnt8 u_pulse_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (is_commit && win_oflow_q),
      .cnt_o (oflow_pulse_cnt)
   );

   // Trigger edges that arrived while a pulse was still being sequenced.
   sat_cnt8 u_missed_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (trig_edge_q && busy),
      .cnt_o (missed_trig)
   );

   assign tap_weight   = tap_weight_q;
   assign acc_clr_en   = acc_clr_en_q;
   assign oflow_status = oflow_status_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_antidroop_ctrl.sv
// Directed bench for antidroop_ctrl with a short window (4) and holdoff (2).
// Offsets j below count clock edges after the edge that sampled trig high:
// window at j=2..5, holdoff j=6..7, commit j=8, idle again at j=9.
module tb_antidroop_ctrl;

   localparam int NCH = 3;
   localparam int WL  = 4;
   localparam int HL  = 2;
   localparam int TW  = NCH * 7;

   logic            clk;
   logic            rst_n;
   logic            trig;
   logic            cfg_wr;
   logic [1:0]      cfg_addr;
   logic [7:0]      cfg_data;
   logic [NCH-1:0]  oflow_in;
   logic [TW-1:0]   tap_weight;
   logic            acc_clr_en;
   logic            oflow_clr;
   logic            window;
   logic            busy;
   logic            commit_done;
   logic [NCH-1:0]  oflow_status;
   logic [7:0]      oflow_pulse_cnt;
   logic [7:0]      missed_trig;
   logic [1:0]      dbg_state;

   int errors = 0;
   int checks = 0;

   // Expected committed weight words, in commit order.
   logic [TW-1:0] exp_q[$];

   antidroop_ctrl #(
      .NCH         (NCH),
      .WINDOW_LEN  (WL),
      .HOLDOFF_LEN (HL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .trig            (trig),
      .cfg_wr          (cfg_wr),
      .cfg_addr        (cfg_addr),
      .cfg_data        (cfg_data),
      .oflow_in        (oflow_in),
      .tap_weight      (tap_weight),
      .acc_clr_en      (acc_clr_en),
      .oflow_clr       (oflow_clr),
      .window          (window),
      .busy            (busy),
      .commit_done     (commit_done),
      .oflow_status    (oflow_status),
      .oflow_pulse_cnt (oflow_pulse_cnt),
      .missed_trig     (missed_trig),
      .dbg_state       (dbg_state)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      cfg_wr   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      step();
      cfg_wr   = 1'b0;
   endtask

   // Hold trig high for exactly one sampling edge; returns at offset 0.
   task automatic fire_trig();
      trig = 1'b1;
      step();
      trig = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (tap_weight !== '0) begin errors++; $display("FAIL reset_tap got=%h exp=0", tap_weight); end
      checks++; if (acc_clr_en !== 1'b0) begin errors++; $display("FAIL reset_acc got=%b exp=0", acc_clr_en); end
      checks++; if (oflow_clr !== 1'b0) begin errors++; $display("FAIL reset_oclr got=%b exp=0", oflow_clr); end
      checks++; if (window !== 1'b0) begin errors++; $display("FAIL reset_window got=%b exp=0", window); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit_done); end
      checks++; if (oflow_status !== '0) begin errors++; $display("FAIL reset_status got=%b exp=0", oflow_status); end
      checks++; if (oflow_pulse_cnt !== 8'd0) begin errors++; $display("FAIL reset_pcnt got=%0d exp=0", oflow_pulse_cnt); end
      checks++; if (missed_trig !== 8'd0) begin errors++; $display("FAIL reset_missed got=%0d exp=0", missed_trig); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
   endtask

   // Weights {5,-3,63}; full cycle-by-cycle timing of one pulse.
   task automatic test_timing_weights();
      logic [TW-1:0] exp_tap;
      logic          exp_win, exp_busy, exp_cd;
      cfg_write(2'd0, 8'h05);
      cfg_write(2'd1, 8'h7D);
      cfg_write(2'd2, 8'h3F);
      exp_q.push_back({7'h3F, 7'h7D, 7'h05});
      checks++; if (tap_weight !== '0) begin errors++; $display("FAIL tw_pre_tap got=%h exp=0", tap_weight); end
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         exp_win  = (j >= 2) && (j <= 5);
         exp_busy = (j >= 2) && (j <= 8);
         exp_cd   = (j == 8);
         exp_tap  = (j <= 8) ? '0 : exp_q[0];
         checks++; if (window !== exp_win) begin errors++; $display("FAIL tw_window j=%0d got=%b exp=%b", j, window, exp_win); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL tw_busy j=%0d got=%b exp=%b", j, busy, exp_busy); end
         checks++; if (commit_done !== exp_cd) begin errors++; $display("FAIL tw_commit j=%0d got=%b exp=%b", j, commit_done, exp_cd); end
         checks++; if (tap_weight !== exp_tap) begin errors++; $display("FAIL tw_tap j=%0d got=%h exp=%h", j, tap_weight, exp_tap); end
      end
      checks++; if (acc_clr_en !== 1'b0) begin errors++; $display("FAIL tw_acc got=%b exp=0", acc_clr_en); end
   endtask

   // One extra trigger inside the window is counted and does not stretch it.
   task automatic test_missed();
      int n_win;
      n_win = 0;
      fire_trig();
      for (int j = 1; j <= 12; j++) begin
         step();
         if (j == 3) trig = 1'b1;
         if (j == 4) trig = 1'b0;
         if (window === 1'b1) n_win++;
      end
      checks++; if (n_win != WL) begin errors++; $display("FAIL missed_winlen got=%0d exp=%0d", n_win, WL); end
      checks++; if (missed_trig !== 8'd1) begin errors++; $display("FAIL missed_one got=%0d exp=1", missed_trig); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL missed_idle got=%b exp=0", busy); end
   endtask

   // Toggle trig every cycle: far more than 255 edges land while busy.
   task automatic test_saturation();
      for (int i = 0; i < 2000; i++) begin
         trig = ~trig;
         step();
      end
      trig = 1'b0;
      repeat (20) step();
      checks++; if (missed_trig !== 8'd255) begin errors++; $display("FAIL sat_missed got=%0d exp=255", missed_trig); end
      for (int i = 0; i < 100; i++) begin
         trig = ~trig;
         step();
      end
      trig = 1'b0;
      repeat (20) step();
      checks++; if (missed_trig !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", missed_trig); end
      checks++; if (tap_weight !== exp_q[0]) begin errors++; $display("FAIL sat_tap got=%h exp=%h", tap_weight, exp_q[0]); end
   endtask

   task automatic test_overflow();
      int n_clr;
      // Single overflow cycle inside the window.
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (j == 3) oflow_in = 3'b010;
         if (j == 4) oflow_in = 3'b000;
         if (j == 5) begin
            checks++; if (oflow_status !== 3'b010) begin errors++; $display("FAIL of_status_win got=%b exp=010", oflow_status); end
         end
         if (j == 8) begin
            checks++; if (oflow_clr !== 1'b0) begin errors++; $display("FAIL of_noclr got=%b exp=0", oflow_clr); end
         end
      end
      checks++; if (oflow_pulse_cnt !== 8'd1) begin errors++; $display("FAIL of_pcnt got=%0d exp=1", oflow_pulse_cnt); end
      checks++; if (oflow_status !== 3'b010) begin errors++; $display("FAIL of_sticky got=%b exp=010", oflow_status); end
      // Overflow seen while idle is sticky but is not a window overflow.
      oflow_in = 3'b100;
      step();
      oflow_in = 3'b000;
      step();
      checks++; if (oflow_status !== 3'b110) begin errors++; $display("FAIL of_idle got=%b exp=110", oflow_status); end
      // Clear request plus acc_clr_en, applied at the next commit.
      cfg_write(2'd3, 8'h03);
      checks++; if (acc_clr_en !== 1'b0) begin errors++; $display("FAIL of_acc_pre got=%b exp=0", acc_clr_en); end
      n_clr = 0;
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (oflow_clr === 1'b1) n_clr++;
         if (j == 8) begin
            checks++; if (oflow_clr !== 1'b1) begin errors++; $display("FAIL of_clr got=%b exp=1", oflow_clr); end
         end
      end
      checks++; if (n_clr != 1) begin errors++; $display("FAIL of_clr_count got=%0d exp=1", n_clr); end
      checks++; if (oflow_status !== 3'b000) begin errors++; $display("FAIL of_cleared got=%b exp=000", oflow_status); end
      checks++; if (acc_clr_en !== 1'b1) begin errors++; $display("FAIL of_acc got=%b exp=1", acc_clr_en); end
      checks++; if (oflow_pulse_cnt !== 8'd1) begin errors++; $display("FAIL of_pcnt_keep got=%0d exp=1", oflow_pulse_cnt); end
      // The request was consumed: no strobe on the following commit.
      n_clr = 0;
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (oflow_clr === 1'b1) n_clr++;
      end
      checks++; if (n_clr != 0) begin errors++; $display("FAIL of_clr_once got=%0d exp=0", n_clr); end
   endtask

   // A write landing in the COMMIT cycle misses that commit.
   task automatic test_commit_write();
      logic [TW-1:0] old_tap;
      old_tap = exp_q.pop_front();
      exp_q.push_back({7'h3F, 7'h7D, 7'h11});
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (j == 8) begin
            checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL cw_commit got=%b exp=1", commit_done); end
            cfg_wr   = 1'b1;
            cfg_addr = 2'd0;
            cfg_data = 8'h11;
         end
         if (j == 9) cfg_wr = 1'b0;
      end
      checks++; if (tap_weight !== old_tap) begin errors++; $display("FAIL cw_old got=%h exp=%h", tap_weight, old_tap); end
      fire_trig();
      for (int j = 1; j <= 10; j++) step();
      checks++; if (tap_weight !== exp_q[0]) begin errors++; $display("FAIL cw_new got=%h exp=%h", tap_weight, exp_q[0]); end
   endtask

   // Asynchronous reset during HOLDOFF abandons the pulse.
   task automatic test_reset_mid();
      int n_cd, n_clr;
      cfg_write(2'd1, 8'h22);
      cfg_write(2'd3, 8'h02);
      fire_trig();
      repeat (6) step();
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rm_holdoff got=%0d exp=2", dbg_state); end
      rst_n = 1'b0;
      #1;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rm_state got=%0d exp=0", dbg_state); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (tap_weight !== '0) begin errors++; $display("FAIL rm_tap got=%h exp=0", tap_weight); end
      checks++; if (acc_clr_en !== 1'b0) begin errors++; $display("FAIL rm_acc got=%b exp=0", acc_clr_en); end
      checks++; if (missed_trig !== 8'd0) begin errors++; $display("FAIL rm_missed got=%0d exp=0", missed_trig); end
      n_cd  = 0;
      n_clr = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (commit_done === 1'b1) n_cd++;
         if (oflow_clr === 1'b1) n_clr++;
      end
      checks++; if ((n_cd + n_clr) != 0) begin errors++; $display("FAIL rm_strobes got=%0d exp=0", n_cd + n_clr); end
      rst_n = 1'b1;
      step();
      // Shadows and the clear request were wiped by the reset.
      n_cd  = 0;
      n_clr = 0;
      fire_trig();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (commit_done === 1'b1) n_cd++;
         if (oflow_clr === 1'b1) n_clr++;
      end
      checks++; if (n_cd != 1) begin errors++; $display("FAIL rm_post_commit got=%0d exp=1", n_cd); end
      checks++; if (n_clr != 0) begin errors++; $display("FAIL rm_post_clr got=%0d exp=0", n_clr); end
      checks++; if (tap_weight !== '0) begin errors++; $display("FAIL rm_post_tap got=%h exp=0", tap_weight); end
   endtask

   // Sequence of scenarios and final report.
   initial begin
      rst_n    = 1'b0;
      trig     = 1'b0;
      cfg_wr   = 1'b0;
      cfg_addr = 2'd0;
      cfg_data = 8'd0;
      oflow_in = '0;
      repeat (3) step();
      test_reset();
      rst_n = 1'b1;
      step();
      test_timing_weights();
      test_missed();
      test_saturation();
      test_overflow();
      test_commit_write();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
